mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the RV64 EX stage. It accepts an M-extension operation from the pipeline alongside the single-cycle ALU, runs an iterative shift-add multiply or restoring divide, and holds the pipeline via `busy` until the result is ready. `word_op` follows the same meaning as the ALU's `WordOp`: a 32-bit operation whose result is sign-extended to 64 bits.

---
 rtl/mdu_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative multiply/divide unit for the RV64 EX stage.
// Shift-add multiply and restoring divide, one bit per cycle. The pipeline is
// held via busy until a one-cycle done pulse presents the sign-corrected result.
module mdu_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            word_op,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam int HW = XLEN / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Control state (reset)
    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic            word_q;
    logic            illegal_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    // Datapath state (no reset; always loaded on accept before use)
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvsr_q;
    logic [XLEN:0]     rem_q;

    // Request decode and operand preparation
    logic            accept_d;
    logic            op_is_div_d;
    logic            op_signed_d;
    logic            op_illegal_d;
    logic            a_neg_d;
    logic            b_neg_d;
    logic            b_zero_d;
    logic            fast_path_d;
    logic [XLEN-1:0] word_mask_d;
    logic [XLEN-1:0] a_ext_d;
    logic [XLEN-1:0] b_ext_d;
    logic [XLEN-1:0] a_mag_d;
    logic [XLEN-1:0] b_mag_d;

    // Decode the incoming request and form unsigned operand magnitudes
    always_comb begin
        accept_d     = (state_q == S_IDLE) && start && !flush;
        op_is_div_d  = op[2];
        // DIV (100) and REM (110) are the signed divide forms; MUL low bits are sign-agnostic
        op_signed_d  = op[2] && !op[0];
        op_illegal_d = (op == 3'b001) || (op == 3'b010) || ((op == 3'b011) && word_op);
        word_mask_d  = word_op ? {{HW{1'b0}}, {HW{1'b1}}} : {XLEN{1'b1}};
        a_ext_d      = a & word_mask_d;
        b_ext_d      = b & word_mask_d;
        a_neg_d      = op_signed_d && (word_op ? a[HW-1] : a[XLEN-1]);
        b_neg_d      = op_signed_d && (word_op ? b[HW-1] : b[XLEN-1]);
        a_mag_d      = a_neg_d ? ((-a_ext_d) & word_mask_d) : a_ext_d;
        b_mag_d      = b_neg_d ? ((-b_ext_d) & word_mask_d) : b_ext_d;
        b_zero_d     = (b_ext_d == '0);
        fast_path_d  = op_illegal_d || (op_is_div_d && b_zero_d);
    end

    // Restoring divide trial: shift next dividend bit in, try subtracting divisor
    logic [XLEN+1:0] rem_sh_d;
    logic [XLEN+1:0] rem_diff_d;

    // Trial subtraction for one restoring-divide step
    always_comb begin
        rem_sh_d   = {rem_q, quo_q[XLEN-1]};
        rem_diff_d = rem_sh_d - {2'b00, dvsr_q};
    end

    // Final sign fix, output select and word sign-extension
    logic [XLEN-1:0] quo_fix_d;
    logic [XLEN-1:0] rem_fix_d;
    logic [XLEN-1:0] sel_d;
    logic [XLEN-1:0] fix_val_d;

    // Assemble the value written to result in FIX
    always_comb begin
        quo_fix_d = neg_quo_q ? -quo_q : quo_q;
        rem_fix_d = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        case (op_q)
            3'b000:         sel_d = acc_q[XLEN-1:0];
            3'b011:         sel_d = acc_q[2*XLEN-1:XLEN];
            3'b100, 3'b101: sel_d = quo_fix_d;
            3'b110, 3'b111: sel_d = rem_fix_d;
            default:        sel_d = '0;
        endcase
        if (illegal_q) begin
            sel_d = '0;
        end
        fix_val_d = word_q ? {{HW{sel_d[HW-1]}}, sel_d[HW-1:0]} : sel_d;
    end

    // Datapath: load operands on accept, iterate one bit per CALC cycle
    always_ff @(posedge clk) begin
        if (accept_d) begin
            acc_q    <= '0;
            mcand_q  <= {{XLEN{1'b0}}, a_ext_d};
            mplier_q <= b_ext_d;
            dvsr_q   <= b_mag_d;
            if (op_is_div_d && b_zero_d) begin
                // Divide by zero: quotient all ones, remainder is the raw dividend
                quo_q <= '1;
                rem_q <= {1'b0, a};
            end else begin
                // Word divides run 32 steps, so the dividend sits in the top half
                quo_q <= word_op ? {a_mag_d[HW-1:0], {HW{1'b0}}} : a_mag_d;
                rem_q <= '0;
            end
        end else if (state_q == S_CALC) begin
            if (op_q[2]) begin
                if (!rem_diff_d[XLEN+1]) begin
                    rem_q <= rem_diff_d[XLEN:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_q <= rem_sh_d[XLEN:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

    // Sequencer FSM with registered busy/done/result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            word_q    <= 1'b0;
            illegal_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        op_q      <= op;
                        word_q    <= word_op;
                        illegal_q <= op_illegal_d;
                        neg_quo_q <= (a_neg_d ^ b_neg_d) && !b_zero_d;
                        neg_rem_q <= a_neg_d && !b_zero_d;
                        cnt_q     <= word_op ? CW'(HW - 1) : CW'(XLEN - 1);
                        busy_q    <= 1'b1;
                        state_q   <= fast_path_d ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= fix_val_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: the driver pushes hand-computed results
// and the expected done cycle; a monitor pops on every done pulse and compares.
module tb_mdu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic        word_op;
    logic        flush;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;

    mdu_sequencer #(.XLEN(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .word_op (word_op),
        .flush   (flush),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    localparam logic [2:0] MUL   = 3'b000;
    localparam logic [2:0] ILL1  = 3'b001;
    localparam logic [2:0] MULHU = 3'b011;
    localparam logic [2:0] DIV   = 3'b100;
    localparam logic [2:0] DIVU  = 3'b101;
    localparam logic [2:0] REM   = 3'b110;
    localparam logic [2:0] REMU  = 3'b111;

    typedef struct {
        logic [63:0] res;
        int          dcyc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          bcnt = 0;
    logic [63:0] last_res = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Monitor: count busy cycles, pop and compare on each done pulse
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (busy === 1'b1) bcnt = bcnt + 1;
        else bcnt = 0;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_result"}, result, e.res);
                check({nm, "_done_cycle"}, 64'(cyc), 64'(e.dcyc));
                check({nm, "_busy_cycles"}, 64'(bcnt), 64'(e.lat));
            end
        end
    end

    // Drive one request at the current negedge; c0 is the accepting edge index
    task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] er, input int lat,
                         input string nm, input bit expect_done, output int c0);
        exp_t e;
        op      = o;
        word_op = w;
        a       = x;
        b       = y;
        start   = 1'b1;
        c0      = cyc + 1;
        if (expect_done) begin
            e.res  = er;
            e.dcyc = c0 + lat - 1;
            e.lat  = lat;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        name_q.delete();
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] o, input logic w, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] er, input int lat,
                       input string nm);
        int c0;
        issue(o, w, x, y, er, lat, nm, 1'b1, c0);
        wait_idle(nm);
        last_res = er;
    endtask

    initial begin
        int c0;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = '0;
        word_op = 1'b0;
        flush   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(MUL,   1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, "mul");
        run(MULHU, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 66, "mulhu");
        run(MUL,   1'b1, 64'hDEAD_BEEF_0001_0000, 64'h0000_0000_0000_8000,
            64'hFFFF_FFFF_8000_0000, 34, "mulw");
        run(DIV,   1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, "divw");
        run(REM,   1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, "remw");
        run(DIVU,  1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34, "divuw");
        run(DIVU,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, "divu_by0");
        run(REMU,  1'b0, 64'd5, 64'd0, 64'd5, 2, "remu_by0");
        run(REMU,  1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000,
            64'hFFFF_FFFF_9ABC_DEF0, 2, "remuw_by0");
        run(DIV,   1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 66, "div_ovf");
        run(REM,   1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66, "rem_ovf");
        run(DIV,   1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 34, "divw_ovf");
        run(ILL1,  1'b0, 64'd9, 64'd9, 64'd0, 2, "illegal_001");
        run(MULHU, 1'b1, 64'd9, 64'd9, 64'd0, 2, "illegal_mulhuw");
        run(DIV,   1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66, "div_neg");
        run(REM,   1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, "rem_neg");

        // Flush during CALC: request at edge c0, flush sampled at the end of cycle 10
        issue(MUL, 1'b0, 64'd3, 64'd5, 64'd0, 66, "flushed", 1'b0, c0);
        for (int k = 0; k < 100 && cyc != c0 + 9; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_low", 64'(busy), 64'd0);
        check("flush_result_kept", result, last_res);
        issue(DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, "after_flush", 1'b1, c0);
        wait_idle("after_flush");
        last_res = 64'd14;

        // start pulsed while busy must be ignored
        issue(REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66, "busy_start", 1'b1, c0);
        for (int k = 0; k < 100 && cyc != c0 + 19; k++) @(negedge clk);
        op    = MUL;
        a     = 64'd1;
        b     = 64'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start");
        repeat (80) @(negedge clk);

        // Asynchronous reset in the middle of an operation
        issue(MUL, 1'b0, 64'd11, 64'd13, 64'd143, 66, "reset_mid", 1'b0, c0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(MUL, 1'b0, 64'd11, 64'd13, 64'd143, 66, "mul_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
